// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch queue.
// An entry pairs a fetched word with the pc it was read from.
package fetch_pkg;

  localparam int INSTR_W = 32;

  // Canonical RV32I NOP (addi x0, x0, 0)
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a flush input.
// Storage resets to zero so dout is defined straight out of reset.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign dout      = r_mem[r_rptr];
  assign w_do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= din;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: issues in-order reads at pc, pairs returning words with their pc,
// and buffers them for decode. Redirects flush the queue and drop stale responses.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        pc,
  output logic               pc_advance,
  input  logic               redirect,
  output logic               imem_req_valid,
  output logic [31:0]        imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [31:0]        out_pc,
  input  logic               out_ready
);

  localparam int SUM_W = CNT_W + 2;

  logic [CNT_W-1:0] r_occupancy;
  logic [CNT_W-1:0] r_inflight;
  logic [CNT_W-1:0] r_drop_cnt;

  logic [SUM_W-1:0] w_reserved;
  logic             w_accept;
  logic             w_resp_expected;
  logic             w_resp_drop;
  logic             w_resp_keep;
  logic             w_q_push;
  logic             w_q_pop;
  logic             w_q_empty;
  logic             w_q_full;
  logic [31:0]      w_pc_head;
  logic             w_pc_empty;
  logic             w_pc_full;
  fetch_entry_t     w_q_din;
  fetch_entry_t     w_q_dout;

  // Every outstanding request, live or stale, holds a queue slot until it returns
  assign w_reserved = SUM_W'(r_occupancy) + SUM_W'(r_inflight) + SUM_W'(r_drop_cnt);

  assign imem_req_valid = reset && !redirect && (w_reserved < SUM_W'(DEPTH));
  assign imem_req_addr  = pc;
  assign w_accept       = imem_req_valid && imem_req_ready;
  assign pc_advance     = w_accept;

  assign w_resp_expected = imem_resp_valid && ((r_drop_cnt != '0) || (r_inflight != '0));
  assign w_resp_drop     = imem_resp_valid && (r_drop_cnt != '0);
  assign w_resp_keep     = imem_resp_valid && (r_drop_cnt == '0) && (r_inflight != '0) && !redirect;

  assign out_valid = !w_q_empty && !redirect;
  assign w_q_pop   = out_valid && out_ready;
  assign w_q_push  = w_resp_keep;

  assign w_q_din.instr = imem_resp_data;
  assign w_q_din.pc    = w_pc_head;
  assign out_instr     = w_q_dout.instr;
  assign out_pc        = w_q_dout.pc;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_pc_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_accept),
    .pop   (w_resp_keep),
    .clear (redirect),
    .din   (pc),
    .dout  (w_pc_head),
    .empty (w_pc_empty),
    .full  (w_pc_full)
  );

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_out_queue (
    .clk   (clk),
    .reset (reset),
    .push  (w_q_push),
    .pop   (w_q_pop),
    .clear (redirect),
    .din   (w_q_din),
    .dout  (w_q_dout),
    .empty (w_q_empty),
    .full  (w_q_full)
  );

  // On redirect, all live requests become stale; a response arriving now retires one of them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_occupancy <= '0;
      r_inflight  <= '0;
      r_drop_cnt  <= '0;
    end else if (redirect) begin
      r_occupancy <= '0;
      r_inflight  <= '0;
      r_drop_cnt  <= r_drop_cnt + r_inflight - CNT_W'(w_resp_expected);
    end else begin
      r_occupancy <= r_occupancy + CNT_W'(w_q_push) - CNT_W'(w_q_pop);
      r_inflight  <= r_inflight + CNT_W'(w_accept) - CNT_W'(w_resp_keep);
      if (w_resp_drop) begin
        r_drop_cnt <= r_drop_cnt - CNT_W'(1);
      end
    end
  end

  a_no_queue_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(w_q_push && w_q_full));

  a_no_unexpected_resp: assert property (@(posedge clk) disable iff (!reset)
    !(imem_resp_valid && (r_inflight == '0) && (r_drop_cnt == '0)));

  a_pc_fifo_consistent: assert property (@(posedge clk) disable iff (!reset)
    !(w_accept && w_pc_full && !w_resp_keep) && !(w_resp_keep && w_pc_empty));

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: a queue-level reference model plus an in-order memory
// with variable latency, with a few directed scenarios pinned to literal expectations.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        pc_advance;
  logic        redirect;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (rst_n),
    .pc              (pc),
    .pc_advance      (pc_advance),
    .redirect        (redirect),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .out_ready       (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } infl_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } memreq_t;

  infl_t   inflQ[$];
  ent_t    outQ[$];
  memreq_t memQ[$];

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;
  int lastDue     = 0;

  int pRedirect, pReady, pOutReady, latMin, latMax;
  bit          forceRedirect = 0;
  logic [31:0] forceTarget   = '0;
  logic [31:0] redirTarget   = '0;

  function automatic logic [31:0] memWord(logic [31:0] a);
    if (a[3:0] == 4'hC) return NOP_INSTR;
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic cmpVal(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic setKnobs(int r, int rdy, int ordy, int lmin, int lmax);
    pRedirect = r;
    pReady    = rdy;
    pOutReady = ordy;
    latMin    = lmin;
    latMax    = lmax;
  endtask

  // Reference expectations from the queue-level view: slots = queued + outstanding requests
  task automatic computeExp(output bit eReqV, output bit eAdv, output bit eOutV);
    eReqV = rst_n && !redirect && ((outQ.size() + inflQ.size()) < DEPTH);
    eAdv  = eReqV && imem_req_ready;
    eOutV = rst_n && (outQ.size() > 0) && !redirect;
  endtask

  task automatic applyStimulus();
    redirect       = rst_n && (forceRedirect || ($urandom_range(0, 99) < pRedirect));
    redirTarget    = forceRedirect ? forceTarget : ($urandom & 32'h0000_0FFC);
    imem_req_ready = ($urandom_range(0, 99) < pReady);
    out_ready      = ($urandom_range(0, 99) < pOutReady);
    if (memQ.size() > 0 && memQ[0].due <= cycle) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = memWord(memQ[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
  endtask

  task automatic checkOutput();
    bit eReqV, eAdv, eOutV;
    computeExp(eReqV, eAdv, eOutV);
    cmpVal("req_valid", {31'b0, imem_req_valid}, {31'b0, eReqV});
    cmpVal("pc_advance", {31'b0, pc_advance}, {31'b0, eAdv});
    cmpVal("out_valid", {31'b0, out_valid}, {31'b0, eOutV});
    if (eReqV) cmpVal("req_addr", imem_req_addr, pc);
    if (eOutV) begin
      cmpVal("out_pc", out_pc, outQ[0].pc);
      cmpVal("out_instr", out_instr, outQ[0].instr);
    end
  endtask

  task automatic updateModel();
    bit    eReqV, eAdv, eOutV;
    infl_t h;
    int    due;
    computeExp(eReqV, eAdv, eOutV);
    if (redirect) begin
      if (imem_resp_valid && inflQ.size() > 0) void'(inflQ.pop_front());
      foreach (inflQ[i]) inflQ[i].stale = 1'b1;
      outQ.delete();
    end else begin
      if (eOutV && out_ready) void'(outQ.pop_front());
      if (imem_resp_valid && inflQ.size() > 0) begin
        h = inflQ.pop_front();
        if (!h.stale) outQ.push_back('{instr: imem_resp_data, pc: h.pc});
      end
      if (eAdv) begin
        inflQ.push_back('{pc: pc, stale: 1'b0});
        due = cycle + $urandom_range(latMin, latMax);
        if (due <= lastDue) due = lastDue + 1;
        lastDue = due;
        memQ.push_back('{addr: pc, due: due});
      end
    end
    if (imem_resp_valid) void'(memQ.pop_front());
    if (redirect) pc = redirTarget;
    else if (eAdv) pc = pc + 32'd4;
    cycle++;
  endtask

  task automatic beginCycle();
    applyStimulus();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic endCycle();
    @(posedge clk);
    #1;
    updateModel();
  endtask

  // Asserted between edges so the outputs must clear asynchronously
  task automatic doReset(int holdCycles);
    rst_n = 1'b0;
    #1;
    cmpVal("rst_out_valid", {31'b0, out_valid}, 32'd0);
    cmpVal("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    cmpVal("rst_pc_advance", {31'b0, pc_advance}, 32'd0);
    cmpVal("rst_out_pc", out_pc, 32'd0);
    cmpVal("rst_out_instr", out_instr, 32'd0);
    inflQ.delete();
    outQ.delete();
    memQ.delete();
    lastDue         = cycle;
    forceRedirect   = 1'b0;
    redirect        = 1'b0;
    imem_resp_valid = 1'b0;
    repeat (holdCycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] s1Instr [4];
    logic [31:0] savedPc;
    int          advCount;
    bit          found;

    rst_n           = 1'b1;
    pc              = '0;
    redirect        = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    out_ready       = 1'b0;
    setKnobs(0, 100, 100, 1, 1);
    @(posedge clk);
    #1;

    // Streaming at one word per cycle, then a redirect colliding with a response and a pop
    s1Instr[0] = 32'h1357_9BDF;
    s1Instr[1] = 32'h1357_9BDB;
    s1Instr[2] = 32'h1357_9BD7;
    s1Instr[3] = NOP_INSTR;
    pc = 32'h0;
    doReset(2);
    for (int c = 0; c < 6; c++) begin
      beginCycle();
      cmpVal("s1_pc_advance", {31'b0, pc_advance}, 32'd1);
      if (c >= 2) begin
        cmpVal("s1_out_valid", {31'b0, out_valid}, 32'd1);
        cmpVal("s1_out_pc", out_pc, 32'(4 * (c - 2)));
        cmpVal("s1_out_instr", out_instr, s1Instr[c-2]);
      end
      endCycle();
    end
    forceRedirect = 1'b1;
    forceTarget   = 32'h200;
    beginCycle();
    cmpVal("s2_redir_resp_present", {31'b0, imem_resp_valid}, 32'd1);
    cmpVal("s2_redir_out_valid", {31'b0, out_valid}, 32'd0);
    cmpVal("s2_redir_pc_advance", {31'b0, pc_advance}, 32'd0);
    endCycle();
    forceRedirect = 1'b0;
    beginCycle();
    cmpVal("s2_post_out_valid", {31'b0, out_valid}, 32'd0);
    endCycle();
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      beginCycle();
      if (out_valid) begin
        found = 1'b1;
        cmpVal("s2_first_pc", out_pc, 32'h200);
      end
      endCycle();
    end
    cmpVal("s2_out_seen", {31'b0, found}, 32'd1);

    // Decode stalled: the queue fills after exactly DEPTH accepts
    pc = 32'h0;
    setKnobs(0, 100, 0, 1, 1);
    doReset(1);
    advCount = 0;
    for (int c = 0; c < 8; c++) begin
      beginCycle();
      advCount += int'(pc_advance);
      endCycle();
    end
    cmpVal("s3_accept_count", 32'(advCount), 32'd4);
    beginCycle();
    cmpVal("s3_stalled_req", {31'b0, imem_req_valid}, 32'd0);
    endCycle();
    pOutReady = 100;
    beginCycle();
    cmpVal("s3_req_at_pop", {31'b0, imem_req_valid}, 32'd0);
    cmpVal("s3_out_valid", {31'b0, out_valid}, 32'd1);
    endCycle();
    pOutReady = 0;
    beginCycle();
    cmpVal("s3_resume", {31'b0, imem_req_valid}, 32'd1);
    endCycle();
    savedPc = pc;
    doReset(2);
    beginCycle();
    cmpVal("s3_restart_valid", {31'b0, imem_req_valid}, 32'd1);
    cmpVal("s3_restart_addr", imem_req_addr, savedPc);
    endCycle();

    // Slow memory: two requests in flight when the redirect hits
    pc = 32'h10;
    setKnobs(0, 100, 100, 3, 3);
    doReset(1);
    beginCycle();
    endCycle();
    beginCycle();
    endCycle();
    forceRedirect = 1'b1;
    forceTarget   = 32'h100;
    beginCycle();
    cmpVal("s4_redir_pc_advance", {31'b0, pc_advance}, 32'd0);
    endCycle();
    forceRedirect = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      beginCycle();
      if (out_valid) begin
        found = 1'b1;
        cmpVal("s4_first_pc", out_pc, 32'h100);
      end
      endCycle();
    end
    cmpVal("s4_out_seen", {31'b0, found}, 32'd1);

    // Randomized traffic across several memory and decode profiles
    for (int s = 0; s < 4; s++) begin
      case (s)
        0:       setKnobs(3, 80, 80, 1, 1);
        1:       setKnobs(6, 60, 50, 1, 3);
        2:       setKnobs(10, 90, 30, 2, 4);
        default: setKnobs(0, 100, 100, 1, 2);
      endcase
      for (int c = 0; c < 600; c++) begin
        if ($urandom_range(0, 399) == 0) doReset(1 + $urandom_range(0, 2));
        beginCycle();
        endCycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
